// File: rtl/video_timing_pattern_gen.sv
// Video timing and test-pattern source: counts pixels/lines for a configurable
// raster, produces VDE and {vsync, hsync}, and paints one of four RGB patterns.
// Every output is registered from the counter state, so all of them arrive one
// pixclk after the counters and stay aligned with one another.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int CHECK_SHIFT = 5,
  parameter int X_W         = 12,
  parameter int Y_W         = 11
) (
  input  logic           pixclk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [1:0]     mode,
  input  logic [23:0]    solid_rgb,
  output logic           VDE,
  output logic [1:0]     CD,
  output logic [7:0]     R_data,
  output logic [7:0]     G_data,
  output logic [7:0]     B_data,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] BAR_LAST = X_W'(BAR_W - 1);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  logic [2:0]     bar_idx_q, bar_idx_d;
  logic [X_W-1:0] bar_pix_q, bar_pix_d;
  logic [1:0]     mode_sh_q, mode_sh_d;
  logic [23:0]    rgb_sh_q, rgb_sh_d;

  logic           vde_q, vde_d;
  logic [1:0]     cd_q, cd_d;
  logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           fs_q, fs_d, ls_q, ls_d;

  logic           active, hs_on, vs_on;
  logic [2:0]     bar_col;
  logic [7:0]     grad_b;

  // Sequencer: FSM, raster counters, bar tracker and per-frame shadow latch.
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q;
    mode_sh_d = mode_sh_q;
    rgb_sh_d  = rgb_sh_q;
    unique case (state_q)
      ST_IDLE: begin
        h_cnt_d   = '0;
        v_cnt_d   = '0;
        bar_idx_d = '0;
        bar_pix_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d   = '0;
          bar_idx_d = '0;
          bar_pix_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            if (!enable) state_d = ST_IDLE;
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
          // Bar index follows x without a divider; bar 7 absorbs the remainder.
          if (bar_idx_q != 3'd7) begin
            if (bar_pix_q == BAR_LAST) begin
              bar_idx_d = bar_idx_q + 1'b1;
              bar_pix_d = '0;
            end else begin
              bar_pix_d = bar_pix_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Shadows load as the counters step onto (0,0) so that pixel already sees them.
    if (state_d == ST_RUN && h_cnt_d == '0 && v_cnt_d == '0) begin
      mode_sh_d = mode;
      rgb_sh_d  = solid_rgb;
    end
  end

  // Output stage: timing flags and pattern colour for the current counter position.
  always_comb begin
    active  = 1'b0;
    hs_on   = 1'b0;
    vs_on   = 1'b0;
    bar_col = 3'd7 - bar_idx_q;
    grad_b  = h_cnt_q[7:0] + v_cnt_q[7:0];
    vde_d   = 1'b0;
    cd_d    = {~VS_POL, ~HS_POL};
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    x_d     = h_cnt_q;
    y_d     = v_cnt_q;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    if (state_q == ST_RUN) begin
      active = (h_cnt_q < H_ACT_X) && (v_cnt_q < V_ACT_Y);
      hs_on  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
      vs_on  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
      cd_d   = {vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
      ls_d   = (h_cnt_q == '0);
      fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (active) begin
        vde_d = 1'b1;
        unique case (mode_sh_q)
          2'd0: begin
            r_d = rgb_sh_q[23:16];
            g_d = rgb_sh_q[15:8];
            b_d = rgb_sh_q[7:0];
          end
          2'd1: begin
            r_d = {8{bar_col[1]}};
            g_d = {8{bar_col[2]}};
            b_d = {8{bar_col[0]}};
          end
          2'd2: begin
            r_d = {8{h_cnt_q[CHECK_SHIFT] ^ v_cnt_q[CHECK_SHIFT]}};
            g_d = r_d;
            b_d = r_d;
          end
          default: begin
            r_d = h_cnt_q[7:0];
            g_d = v_cnt_q[7:0];
            b_d = grad_b;
          end
        endcase
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_idx_q <= '0;
      bar_pix_q <= '0;
      mode_sh_q <= '0;
      rgb_sh_q  <= '0;
      vde_q     <= 1'b0;
      cd_q      <= {~VS_POL, ~HS_POL};
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
      mode_sh_q <= mode_sh_d;
      rgb_sh_q  <= rgb_sh_d;
      vde_q     <= vde_d;
      cd_q      <= cd_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      ls_q      <= ls_d;
    end
  end

  assign VDE         = vde_q;
  assign CD          = cd_q;
  assign R_data      = r_q;
  assign G_data      = g_q;
  assign B_data      = b_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule
